// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM with memory wait/timeout, illegal-opcode pulse and retire counter
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [5:0]       opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             PCWrite,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_EXEC, S_ADDI_WB
  } state_t;
  localparam logic [5:0] OP_R = 6'd0, OP_LW = 6'd35, OP_SW = 6'd43, OP_BEQ = 6'd4,
                         OP_BNE = 6'd5, OP_J = 6'd2, OP_ADDI = 6'd8;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t           r_state, w_next;
  logic [WW-1:0]    r_wait;
  logic             r_illegal, r_timeout;
  logic [CNT_W-1:0] r_count;
  logic             w_wait_st, w_to, w_illegal, w_retire;
  assign w_wait_st = r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  // timeout fires on the MEM_TIMEOUT-th consecutive not-ready cycle; a late ready wins
  assign w_to      = w_wait_st && !mem_ready && r_wait == WW'(MEM_TIMEOUT - 1);
  assign w_illegal = r_state == S_DECODE && w_next == S_FETCH;
  assign w_retire  = (r_state inside {S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB}) ||
                     (r_state == S_MEM_WR && mem_ready);
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    w_next = (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                            opcode == OP_R ? S_R_EXEC :
                            (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH :
                            opcode == OP_J ? S_JUMP :
                            opcode == OP_ADDI ? S_ADDI_EXEC : S_FETCH;
      S_MEM_ADDR:  w_next = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    w_next = mem_ready ? S_MEM_WB : w_to ? S_FETCH : S_MEM_RD;
      S_MEM_WR:    w_next = (mem_ready || w_to) ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    w_next = S_R_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      default:     w_next = S_FETCH;
    endcase
  end
  always_comb begin
    {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA} = 8'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'b00;
    PCWrite  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'b01;
        PCWrite  = opcode == OP_BEQ ? Zero : ~Zero;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      default: ;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_RST;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_next;
      r_wait    <= (w_next != r_state || w_to) ? '0 : (w_wait_st && !mem_ready) ? r_wait + 1'b1 : r_wait;
      r_illegal <= w_illegal;
      r_timeout <= w_to;
      r_count   <= r_count + CNT_W'(w_retire);
    end
  end
  assign state       = r_state;
  assign illegal_op  = r_illegal;
  assign mem_timeout = r_timeout;
  assign instr_count = r_count;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed stimulus, per-cycle instruction-path model compare plus literal pins
module tb_multicycle_control;
  localparam int TO = 16;
  localparam int CW = 4;
  logic          CLK = 1'b0, RESET = 1'b0;
  logic [5:0]    opcode = 6'd0;
  logic          Zero = 1'b0, mem_ready = 1'b1;
  logic          IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite;
  logic [1:0]    ALUSrcB, ALUOp, PCSource;
  logic [3:0]    state;
  logic          illegal_op, mem_timeout;
  logic [CW-1:0] instr_count;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .opcode(opcode), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite), .state(state),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .instr_count(instr_count)
  );
  typedef struct packed { int st; int k; int w; int c; bit il; bit to; } mdl_t;
  mdl_t m;
  // states visited after DECODE for each legal opcode; length 0 marks illegal
  function automatic int route_len(input int op);
    case (op)
      0, 43, 8: return 2;
      35:       return 3;
      4, 5, 2:  return 1;
      default:  return 0;
    endcase
  endfunction
  function automatic int route(input int op, input int k);
    case (op)
      0:       return k == 0 ? 7 : 8;
      35:      return k == 0 ? 3 : k == 1 ? 4 : 5;
      43:      return k == 0 ? 3 : 6;
      4, 5:    return 9;
      2:       return 10;
      8:       return k == 0 ? 11 : 12;
      default: return 1;
    endcase
  endfunction
  function automatic mdl_t mstep(input mdl_t a, input int op, input bit mr);
    mdl_t n;
    n = a;
    n.il = 1'b0;
    n.to = 1'b0;
    if (a.st == 0) n.st = 1;
    else if ((a.st == 1 || a.st == 4 || a.st == 6) && !mr) begin
      n.w = a.w + 1;
      if (n.w == TO) begin
        n.to = 1'b1;
        n.st = 1;
      end
    end else if (a.st == 1) n.st = 2;
    else if (a.st == 2) begin
      if (route_len(op) == 0) begin
        n.il = 1'b1;
        n.st = 1;
      end else begin
        n.k  = 0;
        n.st = route(op, 0);
      end
    end else if (a.k + 1 < route_len(op)) begin
      n.k  = a.k + 1;
      n.st = route(op, n.k);
    end else begin
      n.st = 1;
      n.c  = a.c + 1;
    end
    if (n.st != a.st || n.to) n.w = 0;
    return n;
  endfunction
  // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,PCWrite}
  function automatic logic [14:0] exp_ctl(input int st, input int op, input bit mr, input bit z);
    case (st)
      1:       return {1'b0, 1'b1, 1'b0, mr, 4'b0, 2'b01, 2'b00, 2'b00, mr};
      2:       return {8'b0, 2'b11, 2'b00, 2'b00, 1'b0};
      3, 11:   return {7'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
      4:       return {1'b1, 1'b1, 13'b0};
      5:       return {5'b0, 1'b1, 1'b1, 8'b0};
      6:       return {1'b1, 1'b0, 1'b1, 12'b0};
      7:       return {7'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
      8:       return {4'b0, 1'b1, 1'b0, 1'b1, 8'b0};
      9:       return {7'b0, 1'b1, 2'b00, 2'b01, 2'b01, (op == 4) ? z : ~z};
      10:      return {12'b0, 2'b10, 1'b1};
      12:      return {6'b0, 1'b1, 8'b0};
      default: return 15'b0;
    endcase
  endfunction
  always @(posedge CLK or posedge RESET) m <= RESET ? '0 : mstep(m, int'(opcode), mem_ready);
  logic [24:0] act_all, exp_all;
  assign act_all = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                    ALUSrcB, ALUOp, PCSource, PCWrite, state, illegal_op, mem_timeout, instr_count};
  assign exp_all = {exp_ctl(m.st, int'(opcode), mem_ready, Zero), 4'(m.st), m.il, m.to, 4'(m.c)};
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // every cycle the bench advances, the whole output vector is compared against the model
  task automatic step();
    @(negedge CLK);
    checks++;
    if (act_all !== exp_all) begin
      errors++;
      $display("FAIL model_cycle at %0t: got %h expected %h (model state %0d)", $time, act_all, exp_all, m.st);
    end
    @(posedge CLK);
    #1;
  endtask
  initial begin
    #1 RESET = 1'b1;
    step();
    step();
    chk("rst_state", state, 0);
    chk("rst_count", instr_count, 0);
    RESET = 1'b0;
    chk("rel_state", state, 0);
    step();
    chk("first_fetch", state, 1);
    step();
    chk("r_decode", state, 2);
    step();
    chk("r_exec", state, 7);
    step();
    chk("r_wb_state", state, 8);
    chk("r_wb_regwrite", RegWrite, 1);
    chk("r_wb_regdst", RegDst, 1);
    chk("r_wb_count", instr_count, 0);
    step();
    chk("r_done_state", state, 1);
    chk("r_done_count", instr_count, 1);
    opcode = 6'd35;
    step();
    step();
    step();
    chk("lw_memrd", state, 4);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_state", state, 4);
      chk("lw_wait_memread", MemRead, 1);
      chk("lw_wait_iord", IorD, 1);
      step();
    end
    mem_ready = 1'b1;
    chk("lw_rd_last", state, 4);
    step();
    chk("lw_wb_state", state, 5);
    chk("lw_wb_memtoreg", MemtoReg, 1);
    chk("lw_wb_regwrite", RegWrite, 1);
    step();
    chk("lw_done_count", instr_count, 2);
    opcode = 6'd4;
    Zero = 1'b1;
    step();
    step();
    chk("beq_state", state, 9);
    chk("beq_pcwrite", PCWrite, 1);
    chk("beq_pcsource", PCSource, 1);
    step();
    chk("beq_done_state", state, 1);
    chk("beq_count", instr_count, 3);
    opcode = 6'd5;
    step();
    step();
    chk("bne_state", state, 9);
    chk("bne_pcwrite", PCWrite, 0);
    step();
    chk("bne_count", instr_count, 4);
    opcode = 6'd43;
    Zero = 1'b0;
    step();
    step();
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("sw_wait_state", state, 6);
      step();
    end
    chk("sw_to_state", state, 1);
    chk("sw_to_pulse", mem_timeout, 1);
    chk("sw_to_count", instr_count, 4);
    mem_ready = 1'b1;
    opcode = 6'd63;
    step();
    chk("ill_decode", state, 2);
    chk("to_pulse_end", mem_timeout, 0);
    step();
    chk("ill_state", state, 1);
    chk("ill_pulse", illegal_op, 1);
    chk("ill_count", instr_count, 4);
    opcode = 6'd8;
    step();
    chk("ill_pulse_end", illegal_op, 0);
    repeat (3) step();
    opcode = 6'd4;
    repeat (3) step();
    opcode = 6'd5;
    repeat (3) step();
    opcode = 6'd35;
    mem_ready = 1'b0;
    repeat (2) step();
    mem_ready = 1'b1;
    repeat (5) step();
    chk("mix_count", instr_count, 8);
    mem_ready = 1'b0;
    repeat (16) step();
    chk("fetch_to_state", state, 1);
    chk("fetch_to_pulse", mem_timeout, 1);
    chk("fetch_to_count", instr_count, 8);
    mem_ready = 1'b1;
    opcode = 6'd43;
    repeat (3) step();
    mem_ready = 1'b0;
    step();
    chk("wr_state", state, 6);
    chk("wr_memwrite", MemWrite, 1);
    #2 RESET = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_memwrite", MemWrite, 0);
    chk("async_iord", IorD, 0);
    chk("async_count", instr_count, 0);
    mem_ready = 1'b1;
    opcode = 6'd2;
    step();
    step();
    RESET = 1'b0;
    chk("rel2_state", state, 0);
    step();
    chk("rel2_fetch", state, 1);
    for (int i = 0; i < 16; i++) begin
      repeat (3) step();
      if (i == 14) chk("j_count15", instr_count, 15);
    end
    chk("wrap_count", instr_count, 0);
    chk("wrap_state", state, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
